ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, result codes and command bytes.
// Used by ps2_host_tx and reusable by the keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        BITS,
        ACK,
        WAITIDLE,
        DONE
    } ps2_tx_state_t;

    localparam logic [1:0] PS2_OK      = 2'd0;
    localparam logic [1:0] PS2_NACK    = 2'd1;
    localparam logic [1:0] PS2_TIMEOUT = 2'd2;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_LEN = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for one open-collector PS/2 line.
// Flops reset high (the idle bus level) so reset release never fakes an edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fe
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fe    = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte, check ACK.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [1:0] tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [3:0]    PAR_IDX   = 4'(PS2_FRAME_LEN - 3);

    logic clk_lvl, clk_fe;
    logic data_lvl, data_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_in),
        .level (clk_lvl),
        .fe    (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data_in),
        .level (data_lvl),
        .fe    (data_fe_unused)
    );

    ps2_tx_state_t state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [IW-1:0] inh_cnt, inh_n;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;
    logic          done_q, done_n;
    logic [1:0]    err_q, err_n;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_cnt;
    logic          wd_active;
    logic          wd_hit;

    // Armed only while the device is expected to be clocking; every clock edge rearms it.
    assign wd_active = (state == RELEASE) || (state == BITS) ||
                       (state == ACK) || (state == WAITIDLE);
    assign wd_hit    = wd_active && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (!wd_active || clk_fe)
            wd_cnt <= '0;
        else if (!wd_hit)
            wd_cnt <= wd_cnt + WW'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            par       <= 1'b0;
            bitcnt    <= '0;
            inh_cnt   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= PS2_OK;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            par       <= par_n;
            bitcnt    <= bitcnt_n;
            inh_cnt   <= inh_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        par_n     = par;
        bitcnt_n  = bitcnt;
        inh_n     = inh_cnt;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        err_n     = err_q;

        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n  = tx_data;
                    par_n    = odd_parity(tx_data);
                    bitcnt_n = '0;
                    inh_n    = '0;
                    err_n    = PS2_OK;
                    clk_oe_n = 1'b1;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_n = inh_cnt + IW'(1);
                // Start bit goes low during the final inhibit cycle, overlapping the clock hold.
                if (inh_cnt == INH_START)
                    data_oe_n = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    inh_n     = '0;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_fe) begin
                    data_oe_n = ~shreg[0];
                    shreg_n   = shreg >> 1;
                    bitcnt_n  = bitcnt + 4'd1;
                    state_n   = BITS;
                end
            end
            BITS: begin
                if (clk_fe) begin
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt < PAR_IDX) begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = shreg >> 1;
                    end else if (bitcnt == PAR_IDX) begin
                        data_oe_n = ~par;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fe) begin
                    err_n   = data_lvl ? PS2_NACK : PS2_OK;
                    state_n = WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (clk_lvl && data_lvl)
                    state_n = DONE;
            end
            DONE: begin
                // Hold DONE for the pulse cycle so tx_ready follows tx_done by one cycle.
                if (!done_q)
                    done_n = 1'b1;
                else
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        if (wd_hit) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            err_n     = PS2_TIMEOUT;
            state_n   = DONE;
        end
`endif
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-collector bus plus a PS/2 device clocking model.
// Timeout scenario is exercised when PS2_HOST_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic [1:0] tx_err;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;

    int n_checks = 0;
    int n_errors = 0;

    // clock/reset block
    always #5 clk = ~clk;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // done monitor
    int         done_cnt = 0;
    logic [1:0] last_err = 2'b00;
    logic [1:0] last_oe = 2'b00;
    logic       ready_at_done = 1'b0;
    logic       ready_after_done = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (prev_done)
            ready_after_done <= tx_ready;
        if (tx_done) begin
            done_cnt      <= done_cnt + 1;
            last_err      <= tx_err;
            last_oe       <= {ps2_clk_oe, ps2_data_oe};
            ready_at_done <= tx_ready;
        end
        prev_done <= tx_done;
    end

    // driver tasks
    task automatic request(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(input string tag);
        int wait_n = 0;
        int cnt = 0;
        @(negedge clk);
        while (!ps2_clk_oe && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, "_inh_seen"}, 32'(ps2_clk_oe), 1);
        while (ps2_clk_oe && cnt < 200) begin
            cnt++;
            if (cnt == INH - 1) chk({tag, "_start_early"}, 32'(ps2_data_oe), 0);
            if (cnt == INH)     chk({tag, "_start_last"}, 32'(ps2_data_oe), 1);
            @(negedge clk);
        end
        chk({tag, "_inh_len"}, cnt, INH);
        chk({tag, "_start_hold"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device: smp[0] = start bit, smp[8:1] data, smp[9] parity, smp[10] stop, smp[11] ack line.
    task automatic dev_clock(input int npulses, input logic ack_low, input logic chk_lat,
                             output logic [11:0] smp);
        smp    = '0;
        smp[0] = ps2_data_in;
        for (int k = 1; k <= npulses; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1 && chk_lat) begin
                repeat (2) @(negedge clk);
                chk("lat_2cyc", 32'(ps2_data_oe), 1);
                @(negedge clk);
                chk("lat_3cyc", 32'(ps2_data_oe), 0);
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            smp[k] = ps2_data_in;
            if (k == 10) dev_data_low = ack_low;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    logic [11:0] smp;
    int          base;
    int          wait_n;

    initial begin
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        rst          = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_err", 32'(tx_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", 32'(tx_ready), 1);
        chk("idle_busy", 32'(busy), 0);

        // 0xED with tx_valid held (data switched to 0x55) for the whole transfer
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h55;
        measure_inhibit("ed");
        repeat (10) @(negedge clk);
        dev_clock(11, 1'b1, 1'b1, smp);
        chk("ed_start", 32'(smp[0]), 0);
        chk("ed_data", 32'(smp[8:1]), 8'hED);
        chk("ed_par", 32'(smp[9]), 1);
        chk("ed_stop", 32'(smp[10]), 1);
        chk("ed_ack_line", 32'(smp[11]), 0);
        chk("ed_done_cnt", done_cnt, 1);
        chk("ed_err", 32'(last_err), 0);
        chk("ed_oe_at_done", 32'(last_oe), 0);
        chk("ed_ready_at_done", 32'(ready_at_done), 0);
        chk("ed_ready_after", 32'(ready_after_done), 1);

        // 0x55 picked up only once ready returned
        chk("h55_busy", 32'(busy), 1);
        chk("h55_rts", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        tx_valid = 1'b0;
        dev_clock(11, 1'b1, 1'b1, smp);
        chk("h55_data", 32'(smp[8:1]), 8'h55);
        chk("h55_par", 32'(smp[9]), 1);
        chk("h55_done_cnt", done_cnt, 2);
        chk("h55_err", 32'(last_err), 0);

        // 0xF4: parity 0
        request(8'hF4);
        measure_inhibit("f4");
        repeat (10) @(negedge clk);
        dev_clock(11, 1'b1, 1'b0, smp);
        chk("f4_data", 32'(smp[8:1]), 8'hF4);
        chk("f4_par", 32'(smp[9]), 0);
        chk("f4_stop", 32'(smp[10]), 1);
        chk("f4_done_cnt", done_cnt, 3);
        chk("f4_err", 32'(last_err), 0);

        // 0x00: parity 1, device does not acknowledge
        request(8'h00);
        measure_inhibit("z0");
        repeat (10) @(negedge clk);
        dev_clock(11, 1'b0, 1'b0, smp);
        chk("z0_data", 32'(smp[8:1]), 8'h00);
        chk("z0_par", 32'(smp[9]), 1);
        chk("z0_ack_line", 32'(smp[11]), 1);
        chk("z0_done_cnt", done_cnt, 4);
        chk("nack_err", 32'(last_err), 1);
        chk("nack_oe", 32'(last_oe), 0);
        chk("nack_ready", 32'(tx_ready), 1);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // device stops clocking after data bit 3
        request(8'hFF);
        measure_inhibit("to");
        repeat (10) @(negedge clk);
        base = done_cnt;
        dev_clock(4, 1'b0, 1'b0, smp);
        chk("to_bits", 32'(smp[4:1]), 4'hF);
        chk("to_not_early", done_cnt, base);
        wait_n = 0;
        while (done_cnt == base && wait_n < 1500) begin
            @(negedge clk);
            wait_n++;
        end
        chk("to_seen", 32'(done_cnt != base), 1);
        chk("to_delay_min", 32'(wait_n >= 900), 1);
        chk("to_err", 32'(last_err), 2);
        chk("to_oe", 32'(last_oe), 0);
        repeat (3) @(negedge clk);
        chk("to_ready", 32'(tx_ready), 1);
`endif

        // reset during BITS
        request(8'hED);
        measure_inhibit("rs");
        repeat (10) @(negedge clk);
        dev_clock(2, 1'b0, 1'b0, smp);
        chk("rs_pre_data_oe", 32'(ps2_data_oe), 1);
        chk("rs_pre_busy", 32'(busy), 1);
        base = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("rs_oe_async", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rs_ready", 32'(tx_ready), 1);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_no_done", done_cnt, base);
        chk("rs_oe_after", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
